// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event path: FSM state encoding and default tick-rate constants,
// also used by the clock divider.
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_e;

    localparam int unsigned TICK_HZ          = 100;
    localparam int unsigned DEF_LONG_TICKS   = TICK_HZ;      // 1 s hold
    localparam int unsigned DEF_REPEAT_TICKS = TICK_HZ / 5;  // 5 repeats per second
    localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/button_event_gen_tick_counter.sv
// tick_counter: CNT_W-bit up-counter with synchronous clear, count enable and a terminal-count compare.
// Wrap policy belongs to the owner, which asserts clr when it sees at_term.
module tick_counter
    import button_event_gen_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_term = (count_q == term);

endmodule

// File: rtl/button_event_gen.sv
// button_event_gen: turns the debounced button level into single-cycle press/release/click/long events.
// Auto-repeat while held in LONG is built only when REPEAT_EN is defined.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam bit CFG_OK = (LONG_TICKS >= 2) && (REPEAT_TICKS >= 1) &&
                            ((2 ** CNT_W) > LONG_TICKS) && ((2 ** CNT_W) > REPEAT_TICKS);

    if (!CFG_OK) begin : g_bad_cfg
        $error("button_event_gen: LONG_TICKS/REPEAT_TICKS/CNT_W out of range");
    end

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_TICKS - 1);

    state_e state_q;
    state_e state_d;
    logic   btn_q;
    logic   rise;
    logic   fall;

    logic press_q, press_d;
    logic release_q, release_d;
    logic click_q, click_d;
    logic long_q, long_d;
    logic held_q, held_d;

    logic hold_clr;
    logic hold_en;
    logic hold_at_term;

`ifdef REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_TICKS - 1);

    logic repeat_q, repeat_d;
    logic rep_clr;
    logic rep_en;
    logic rep_at_term;
`endif

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (hold_clr),
        .en      (hold_en),
        .term    (LONG_TERM),
        .at_term (hold_at_term)
    );

`ifdef REPEAT_EN
    tick_counter #(
        .CNT_W (CNT_W)
    ) u_rep_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (rep_clr),
        .en      (rep_en),
        .term    (REPEAT_TERM),
        .at_term (rep_at_term)
    );
`endif

    // fall is tested before tick in every state so a release always beats a coincident tick
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        hold_clr  = 1'b0;
        hold_en   = 1'b0;
`ifdef REPEAT_EN
        repeat_d  = 1'b0;
        rep_clr   = 1'b0;
        rep_en    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d  = ST_PRESSED;
                    press_d  = 1'b1;
                    hold_clr = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    hold_clr  = 1'b1;
                end else if (tick) begin
                    if (hold_at_term) begin
                        state_d  = ST_LONG;
                        long_d   = 1'b1;
                        hold_clr = 1'b1;
`ifdef REPEAT_EN
                        rep_clr  = 1'b1;
`endif
                    end else begin
                        hold_en = 1'b1;
                    end
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end
`ifdef REPEAT_EN
                else if (tick) begin
                    if (rep_at_term) begin
                        rep_clr  = 1'b1;
                        repeat_d = 1'b1;
                    end else begin
                        rep_en = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= btn_level;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

`ifdef REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_press    = long_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen (LONG_TICKS=4, REPEAT_TICKS=2); expectations follow the
// build's REPEAT_EN setting.
module tb_button_event_gen;

    localparam int unsigned LONG   = 4;
    localparam int unsigned REPEAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic btn_level = 1'b0;
    logic press_pulse, release_pulse, click_pulse, long_press, repeat_pulse, held;
    logic [5:0] obs;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // reference model: press bookkeeping in terms of ticks seen since the press
    logic        m_prev = 1'b0;
    logic        m_active = 1'b0;
    logic        m_long = 1'b0;
    int unsigned m_ticks = 0;
    logic [5:0]  exp_v = '0;   // {press, release, click, long, repeat, held}

    always #5 clk = ~clk;

    button_event_gen #(
        .LONG_TICKS   (LONG),
        .REPEAT_TICKS (REPEAT),
        .CNT_W        (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    assign obs = {press_pulse, release_pulse, click_pulse, long_press, repeat_pulse, held};

    task automatic model_step(input logic b, input logic t);
        logic r, f;
        exp_v = '0;
        if (rst) begin
            m_prev = 1'b0; m_active = 1'b0; m_long = 1'b0; m_ticks = 0;
            return;
        end
        r = b && !m_prev;
        f = !b && m_prev;
        m_prev = b;
        if (!m_active) begin
            if (r) begin
                m_active = 1'b1; m_long = 1'b0; m_ticks = 0; exp_v[5] = 1'b1;
            end
        end else if (f) begin
            exp_v[4] = 1'b1;
            exp_v[3] = !m_long;
            m_active = 1'b0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == LONG) begin
                m_long = 1'b1; exp_v[2] = 1'b1;
            end
`ifdef REPEAT_EN
            else if (m_long && ((m_ticks - LONG) % REPEAT == 0)) exp_v[1] = 1'b1;
`endif
        end
        exp_v[0] = m_active;
    endtask

    // drive inputs for one cycle, advance the model at the edge, land 1 time unit after it
    task automatic drive(input logic b, input logic t);
        btn_level = b;
        tick = t;
        @(posedge clk);
        model_step(b, t);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            checks++;
            if (obs !== 6'b0) begin
                errors++; $display("FAIL reset_state i=%0d got=%b exp=000000", i, obs);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_click();
        int unsigned n_press = 0, n_rel = 0, n_click = 0, n_long = 0;
        for (int i = 0; i < 12; i++) begin
            drive(i < 6, (i % 4) == 3);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL click i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            n_press += press_pulse; n_rel += release_pulse; n_click += click_pulse; n_long += long_press;
        end
        checks++;
        if (n_press != 1 || n_rel != 1 || n_click != 1 || n_long != 0) begin
            errors++;
            $display("FAIL click_counts got=%0d/%0d/%0d/%0d exp=1/1/1/0", n_press, n_rel, n_click, n_long);
        end
    endtask

    task automatic test_long_repeat();
        int unsigned n_long = 0, n_rep = 0, n_click = 0, n_rel = 0;
        int unsigned exp_rep;
`ifdef REPEAT_EN
        exp_rep = 2;
`else
        exp_rep = 0;
`endif
        // 34 clks of hold gives 8 ticks after the rise: long at tick 4, repeats at 6 and 8
        for (int i = 0; i < 40; i++) begin
            drive(i < 34, (i % 4) == 3);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL long_repeat i=%0d got=%b exp=%b", i, obs, exp_v);
            end
            n_long += long_press; n_rep += repeat_pulse; n_click += click_pulse; n_rel += release_pulse;
        end
        checks++;
        if (n_long != 1 || n_rep != exp_rep || n_click != 0 || n_rel != 1) begin
            errors++;
            $display("FAIL long_counts got=%0d/%0d/%0d/%0d exp=1/%0d/0/1", n_long, n_rep, n_click, n_rel, exp_rep);
        end
    endtask

    task automatic test_fall_on_terminal_tick();
        drive(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) drive(1'b1, 1'b0);
            drive(k == 3 ? 1'b0 : 1'b1, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL fall_tick k=%0d got=%b exp=%b", k, obs, exp_v);
            end
        end
        checks++;
        if (obs !== 6'b011000) begin
            errors++; $display("FAIL fall_tick_result got=%b exp=011000", obs);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (obs !== 6'b0) begin
                errors++; $display("FAIL fall_tick_after i=%0d got=%b exp=000000", i, obs);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        for (int i = 0; i < 24; i++) drive(1'b1, (i % 4) == 3);
        checks++;
        if (held !== 1'b1) begin
            errors++; $display("FAIL mid_press_held got=%b exp=1", held);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++; $display("FAIL async_reset got=%b exp=000000", obs);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            checks++;
            if (obs !== 6'b0) begin
                errors++; $display("FAIL reset_hold i=%0d got=%b exp=000000", i, obs);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (press_pulse !== (i == 0) || release_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_repress i=%0d got press=%b rel=%b exp press=%0d rel=0",
                         i, press_pulse, release_pulse, i == 0);
            end
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL reset_model i=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    endtask

    task automatic test_idle_ticks();
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b1);
            checks++;
            if (obs !== 6'b0) begin
                errors++; $display("FAIL idle_ticks i=%0d got=%b exp=000000", i, obs);
            end
        end
    endtask

    task automatic test_random();
        logic        b = 1'b0;
        int unsigned run = 0;
        for (int i = 0; i < 2000; i++) begin
            if (run == 0) begin
                b = ~b;
                run = $urandom_range(1, 45);
            end
            run--;
            drive(b, $urandom_range(0, 3) == 0);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_ticks();
        test_click();
        test_long_repeat();
        test_fall_on_terminal_tick();
        test_reset_mid_press();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
